// File: rtl/cv32e40x_pkg.sv
// rtl/cv32e40x_pkg.sv - shared types for the cv32e40x IF stage
package cv32e40x_pkg;

  // Instruction aligner states: S_RESID means res_q holds the halfword at pc_q.
  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGNED,
    S_RESID,
    S_DISCARD
  } align_state_e;

endpackage

// File: rtl/cv32e40x_instr_aligner.sv
// rtl/cv32e40x_instr_aligner.sv - splits word-aligned fetch words into 16/32-bit instructions
// A residual upper halfword is held so word-straddling 32-bit instructions reach the decoder whole.
module cv32e40x_instr_aligner
  import cv32e40x_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_data_i,
  input  logic        fetch_err_i,
  output logic        fetch_ready_o,
  output logic        instr_valid_o,
  output logic [31:0] instr_data_o,
  output logic        instr_is_compressed_o,
  output logic        instr_err_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  align_state_e state_q, state_d;
  logic [31:1]  pc_q, pc_d;
  logic [15:0]  res_q, res_d;
  logic         res_err_q, res_err_d;
  logic         fetch_xfer;

  assign fetch_xfer = fetch_valid_i & instr_ready_i;
  assign instr_pc_o = {pc_q, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      res_q     <= '0;
      res_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      res_q     <= res_d;
      res_err_q <= res_err_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    pc_d                  = pc_q;
    res_d                 = res_q;
    res_err_d             = res_err_q;
    instr_valid_o         = 1'b0;
    fetch_ready_o         = 1'b0;
    instr_data_o          = 32'h0;
    instr_err_o           = 1'b0;
    instr_is_compressed_o = 1'b0;

    case (state_q)
      S_IDLE: begin
      end
      S_ALIGNED: begin
        instr_valid_o = fetch_valid_i;
        fetch_ready_o = instr_ready_i;
        instr_err_o   = fetch_err_i;
        if (fetch_data_i[1:0] == 2'b11) begin
          instr_data_o = fetch_data_i;
          if (fetch_xfer) pc_d = pc_q + 31'd2;
        end else begin
          instr_data_o          = {16'h0, fetch_data_i[15:0]};
          instr_is_compressed_o = 1'b1;
          if (fetch_xfer) begin
            pc_d      = pc_q + 31'd1;
            res_d     = fetch_data_i[31:16];
            res_err_d = fetch_err_i;
            state_d   = S_RESID;
          end
        end
      end
      S_RESID: begin
        // A compressed residual needs no new fetch word, so it never stalls on fetch.
        if (res_q[1:0] != 2'b11) begin
          instr_valid_o         = 1'b1;
          instr_data_o          = {16'h0, res_q};
          instr_err_o           = res_err_q;
          instr_is_compressed_o = 1'b1;
          if (instr_ready_i) begin
            pc_d    = pc_q + 31'd1;
            state_d = S_ALIGNED;
          end
        end else begin
          instr_valid_o = fetch_valid_i;
          fetch_ready_o = instr_ready_i;
          instr_data_o  = {fetch_data_i[15:0], res_q};
          instr_err_o   = res_err_q | fetch_err_i;
          if (fetch_xfer) begin
            pc_d      = pc_q + 31'd2;
            res_d     = fetch_data_i[31:16];
            res_err_d = fetch_err_i;
          end
        end
      end
      S_DISCARD: begin
        fetch_ready_o = 1'b1;
        if (fetch_valid_i) begin
          res_d     = fetch_data_i[31:16];
          res_err_d = fetch_err_i;
          state_d   = S_RESID;
        end
      end
    endcase

    if (branch_i) begin
      instr_valid_o = 1'b0;
      fetch_ready_o = 1'b0;
      pc_d          = branch_addr_i[31:1];
      res_d         = '0;
      res_err_d     = 1'b0;
      state_d       = branch_addr_i[1] ? S_DISCARD : S_ALIGNED;
    end
  end

endmodule

// File: tb/tb_cv32e40x_instr_aligner.sv
// tb/tb_cv32e40x_instr_aligner.sv - self-checking bench for the instruction aligner
module tb_cv32e40x_instr_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_data_i;
  logic        fetch_err_i;
  logic        fetch_ready_o;
  logic        instr_valid_o;
  logic [31:0] instr_data_o;
  logic        instr_is_compressed_o;
  logic        instr_err_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  int errors = 0;
  int checks = 0;

  // Halfword-addressed program image (2 KiB, address bits [10:1]) with per-word bus error flags.
  logic [15:0] mem   [0:1023];
  logic        err_w [0:511];
  logic [31:0] fetch_addr;

  logic [31:0] o_data[$], o_pc[$];
  logic        o_err[$], o_comp[$], o_fr[$];
  int          o_cyc[$];
  int          fetch_cnt;
  logic [31:0] e_data[$], e_pc[$];
  logic        e_err[$], e_comp[$];

  always #5 clk = ~clk;

  assign fetch_data_i = {mem[fetch_addr[10:1] + 10'd1], mem[fetch_addr[10:1]]};
  assign fetch_err_i  = err_w[fetch_addr[10:2]];

  cv32e40x_instr_aligner dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .branch_i              (branch_i),
    .branch_addr_i         (branch_addr_i),
    .fetch_valid_i         (fetch_valid_i),
    .fetch_data_i          (fetch_data_i),
    .fetch_err_i           (fetch_err_i),
    .fetch_ready_o         (fetch_ready_o),
    .instr_valid_o         (instr_valid_o),
    .instr_data_o          (instr_data_o),
    .instr_is_compressed_o (instr_is_compressed_o),
    .instr_err_o           (instr_err_o),
    .instr_pc_o            (instr_pc_o),
    .instr_ready_i         (instr_ready_i)
  );

  task automatic write_word(input logic [31:0] addr, input logic [31:0] w, input logic e);
    mem[addr[10:1]]         = w[15:0];
    mem[addr[10:1] + 10'd1] = w[31:16];
    err_w[addr[10:2]]       = e;
  endtask

  task automatic exp_push(input logic [31:0] d, input logic [31:0] pc, input logic e);
    e_data.push_back(d);
    e_pc.push_back(pc);
    e_err.push_back(e);
    e_comp.push_back(d[1:0] != 2'b11);
  endtask

  // Reference: walk the program image halfword by halfword from the branch target.
  task automatic build_expected(input logic [31:0] start, input int n);
    logic [31:0] pc, p2;
    logic [15:0] hw;
    pc = start;
    for (int i = 0; i < n; i++) begin
      hw = mem[pc[10:1]];
      p2 = pc + 32'd2;
      if (hw[1:0] == 2'b11) begin
        exp_push({mem[p2[10:1]], hw}, pc, err_w[pc[10:2]] | err_w[p2[10:2]]);
        pc = pc + 32'd4;
      end else begin
        exp_push({16'h0, hw}, pc, err_w[pc[10:2]]);
        pc = p2;
      end
    end
  endtask

  task automatic do_branch(input logic [31:0] addr, input logic rdy, output logic v, output logic r);
    @(negedge clk);
    branch_i      = 1'b1;
    branch_addr_i = addr;
    fetch_valid_i = 1'b1;
    instr_ready_i = rdy;
    #1;
    v = instr_valid_o;
    r = fetch_ready_o;
    @(posedge clk);
    #1;
    branch_i      = 1'b0;
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b0;
    fetch_addr    = {addr[31:2], 2'b00};
    o_data.delete(); o_pc.delete(); o_err.delete(); o_comp.delete(); o_fr.delete(); o_cyc.delete();
    e_data.delete(); e_pc.delete(); e_err.delete(); e_comp.delete();
    fetch_cnt = 0;
  endtask

  // Prefetcher and decoder model: random valid/ready, records every transferred instruction.
  task automatic run_stream(input int n, input int vp, input int rp);
    int  cyc;
    logic took;
    cyc = 0;
    while (o_data.size() < n && cyc < 400) begin
      @(negedge clk);
      fetch_valid_i = ($urandom_range(99) < vp);
      instr_ready_i = ($urandom_range(99) < rp);
      #1;
      if (instr_valid_o && instr_ready_i) begin
        o_data.push_back(instr_data_o);
        o_pc.push_back(instr_pc_o);
        o_err.push_back(instr_err_o);
        o_comp.push_back(instr_is_compressed_o);
        o_fr.push_back(fetch_ready_o);
        o_cyc.push_back(cyc);
      end
      took = fetch_valid_i && fetch_ready_o;
      @(posedge clk);
      #1;
      if (took) begin
        fetch_addr = fetch_addr + 32'd4;
        fetch_cnt++;
      end
      cyc++;
    end
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0;
    fetch_valid_i = 1'b1; instr_ready_i = 1'b1; fetch_addr = 32'h0;
    #2;
    checks++;
    if ({instr_valid_o, fetch_ready_o, instr_data_o, instr_is_compressed_o, instr_err_o, instr_pc_o} !== 67'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b r=%b d=%h c=%b e=%b pc=%h want all 0", instr_valid_o, fetch_ready_o,
               instr_data_o, instr_is_compressed_o, instr_err_o, instr_pc_o);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({instr_valid_o, fetch_ready_o, instr_data_o, instr_is_compressed_o, instr_err_o, instr_pc_o} !== 67'h0) begin
        errors++;
        $display("FAIL idle_outputs cycle %0d: got v=%b r=%b d=%h pc=%h want all 0", i, instr_valid_o,
                 fetch_ready_o, instr_data_o, instr_pc_o);
      end
    end
    fetch_valid_i = 1'b0; instr_ready_i = 1'b0;
  endtask

  task automatic test_aligned32;
    logic v, r;
    write_word(32'h100, 32'h00A00093, 1'b0);
    write_word(32'h104, 32'h00B00113, 1'b0);
    do_branch(32'h100, 1'b1, v, r);
    checks++;
    if ({v, r} !== 2'b00) begin
      errors++; $display("FAIL branch_cycle_aligned32: got v=%b r=%b want 0 0", v, r);
    end
    exp_push(32'h00A00093, 32'h100, 1'b0);
    exp_push(32'h00B00113, 32'h104, 1'b0);
    run_stream(2, 100, 100);
    checks++;
    if (o_data.size() != e_data.size()) begin
      errors++; $display("FAIL aligned32_count: got %0d instrs want %0d", o_data.size(), e_data.size());
    end
    for (int i = 0; i < o_data.size() && i < e_data.size(); i++) begin
      checks++;
      if ({o_data[i], o_pc[i], o_err[i], o_comp[i]} !== {e_data[i], e_pc[i], e_err[i], e_comp[i]}) begin
        errors++;
        $display("FAIL aligned32 #%0d: got d=%h pc=%h e=%b c=%b want d=%h pc=%h e=%b c=%b", i, o_data[i], o_pc[i],
                 o_err[i], o_comp[i], e_data[i], e_pc[i], e_err[i], e_comp[i]);
      end
    end
    checks++;
    if (fetch_cnt != 2 || o_cyc.size() < 1 || o_cyc[0] != 0) begin
      errors++; $display("FAIL aligned32_timing: got fetches=%0d want 2, first instr at cycle 0", fetch_cnt);
    end
  endtask

  task automatic test_compressed_pair;
    logic v, r;
    write_word(32'h200, 32'h41514505, 1'b0);
    write_word(32'h204, 32'h00A00093, 1'b0);
    do_branch(32'h200, 1'b1, v, r);
    exp_push(32'h00004505, 32'h200, 1'b0);
    exp_push(32'h00004151, 32'h202, 1'b0);
    exp_push(32'h00A00093, 32'h204, 1'b0);
    run_stream(3, 100, 100);
    checks++;
    if (o_data.size() != e_data.size()) begin
      errors++; $display("FAIL cpair_count: got %0d instrs want %0d", o_data.size(), e_data.size());
    end
    for (int i = 0; i < o_data.size() && i < e_data.size(); i++) begin
      checks++;
      if ({o_data[i], o_pc[i], o_err[i], o_comp[i]} !== {e_data[i], e_pc[i], e_err[i], e_comp[i]}) begin
        errors++;
        $display("FAIL cpair #%0d: got d=%h pc=%h e=%b c=%b want d=%h pc=%h e=%b c=%b", i, o_data[i], o_pc[i],
                 o_err[i], o_comp[i], e_data[i], e_pc[i], e_err[i], e_comp[i]);
      end
    end
    checks++;
    if (o_fr.size() < 2 || o_fr[1] !== 1'b0 || fetch_cnt != 2) begin
      errors++; $display("FAIL cpair_fetch_ready: got fetches=%0d want 2 with fetch_ready_o=0 on 0x202", fetch_cnt);
    end
  endtask

  task automatic test_straddle;
    logic v, r;
    write_word(32'h300, 32'h00934505, 1'b0);
    write_word(32'h304, 32'h450100A0, 1'b0);
    do_branch(32'h300, 1'b1, v, r);
    exp_push(32'h00004505, 32'h300, 1'b0);
    exp_push(32'h00A00093, 32'h302, 1'b0);
    exp_push(32'h00004501, 32'h306, 1'b0);
    run_stream(3, 100, 100);
    checks++;
    if (o_data.size() != e_data.size()) begin
      errors++; $display("FAIL straddle_count: got %0d instrs want %0d", o_data.size(), e_data.size());
    end
    for (int i = 0; i < o_data.size() && i < e_data.size(); i++) begin
      checks++;
      if ({o_data[i], o_pc[i], o_err[i], o_comp[i]} !== {e_data[i], e_pc[i], e_err[i], e_comp[i]}) begin
        errors++;
        $display("FAIL straddle #%0d: got d=%h pc=%h e=%b c=%b want d=%h pc=%h e=%b c=%b", i, o_data[i], o_pc[i],
                 o_err[i], o_comp[i], e_data[i], e_pc[i], e_err[i], e_comp[i]);
      end
    end
  endtask

  task automatic test_discard;
    logic v, r;
    write_word(32'h400, 32'h45851234, 1'b0);
    write_word(32'h404, 32'h00B00113, 1'b0);
    do_branch(32'h402, 1'b1, v, r);
    exp_push(32'h00004585, 32'h402, 1'b0);
    exp_push(32'h00B00113, 32'h404, 1'b0);
    run_stream(2, 100, 100);
    checks++;
    if (o_data.size() != e_data.size()) begin
      errors++; $display("FAIL discard_count: got %0d instrs want %0d", o_data.size(), e_data.size());
    end
    for (int i = 0; i < o_data.size() && i < e_data.size(); i++) begin
      checks++;
      if ({o_data[i], o_pc[i], o_err[i], o_comp[i]} !== {e_data[i], e_pc[i], e_err[i], e_comp[i]}) begin
        errors++;
        $display("FAIL discard #%0d: got d=%h pc=%h e=%b c=%b want d=%h pc=%h e=%b c=%b", i, o_data[i], o_pc[i],
                 o_err[i], o_comp[i], e_data[i], e_pc[i], e_err[i], e_comp[i]);
      end
    end
    checks++;
    if (o_cyc.size() < 1 || o_cyc[0] != 1) begin
      errors++; $display("FAIL discard_bubble: got first instr at cycle %0d want 1", o_cyc.size() ? o_cyc[0] : -1);
    end
  endtask

  task automatic test_errors;
    logic v, r;
    write_word(32'h500, 32'h00934505, 1'b0);
    write_word(32'h504, 32'h450100A0, 1'b1);
    do_branch(32'h500, 1'b1, v, r);
    exp_push(32'h00004505, 32'h500, 1'b0);
    exp_push(32'h00A00093, 32'h502, 1'b1);
    exp_push(32'h00004501, 32'h506, 1'b1);
    run_stream(3, 100, 100);
    checks++;
    if (o_data.size() != e_data.size()) begin
      errors++; $display("FAIL errors_count: got %0d instrs want %0d", o_data.size(), e_data.size());
    end
    for (int i = 0; i < o_data.size() && i < e_data.size(); i++) begin
      checks++;
      if ({o_data[i], o_pc[i], o_err[i], o_comp[i]} !== {e_data[i], e_pc[i], e_err[i], e_comp[i]}) begin
        errors++;
        $display("FAIL errors #%0d: got d=%h pc=%h e=%b c=%b want d=%h pc=%h e=%b c=%b", i, o_data[i], o_pc[i],
                 o_err[i], o_comp[i], e_data[i], e_pc[i], e_err[i], e_comp[i]);
      end
    end
  endtask

  task automatic test_branch_in_resid;
    logic v, r;
    write_word(32'h600, 32'h41514505, 1'b0);
    write_word(32'h700, 32'h00B00113, 1'b0);
    do_branch(32'h600, 1'b1, v, r);
    run_stream(1, 100, 100);
    @(negedge clk);
    fetch_valid_i = 1'b1; instr_ready_i = 1'b0;
    #1;
    checks++;
    if ({instr_valid_o, instr_data_o, instr_pc_o} !== {1'b1, 32'h00004151, 32'h602}) begin
      errors++;
      $display("FAIL resid_hold: got v=%b d=%h pc=%h want v=1 d=00004151 pc=00000602", instr_valid_o, instr_data_o,
               instr_pc_o);
    end
    do_branch(32'h700, 1'b0, v, r);
    checks++;
    if ({v, r} !== 2'b00) begin
      errors++; $display("FAIL branch_in_resid: got v=%b r=%b want 0 0", v, r);
    end
    run_stream(1, 100, 100);
    checks++;
    if (o_data.size() != 1 || o_data[0] !== 32'h00B00113 || o_pc[0] !== 32'h700) begin
      errors++;
      $display("FAIL after_branch_resid: got n=%0d d=%h pc=%h want d=00b00113 pc=00000700", o_data.size(),
               o_data.size() ? o_data[0] : 32'h0, o_pc.size() ? o_pc[0] : 32'h0);
    end
  endtask

  task automatic test_reset_mid;
    logic v, r;
    do_branch(32'h200, 1'b1, v, r);
    run_stream(1, 100, 100);
    @(negedge clk);
    fetch_valid_i = 1'b1; instr_ready_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({instr_valid_o, fetch_ready_o, instr_data_o, instr_is_compressed_o, instr_err_o, instr_pc_o} !== 67'h0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b r=%b d=%h pc=%h want all 0", instr_valid_o, fetch_ready_o, instr_data_o,
               instr_pc_o);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({instr_valid_o, fetch_ready_o, instr_pc_o} !== 34'h0) begin
      errors++; $display("FAIL idle_after_reset: got v=%b r=%b pc=%h want 0", instr_valid_o, fetch_ready_o, instr_pc_o);
    end
    do_branch(32'h100, 1'b1, v, r);
    run_stream(1, 100, 100);
    checks++;
    if (o_data.size() != 1 || o_data[0] !== 32'h00A00093 || o_pc[0] !== 32'h100) begin
      errors++;
      $display("FAIL recover_after_reset: got n=%0d d=%h want d=00a00093 pc=00000100", o_data.size(),
               o_data.size() ? o_data[0] : 32'h0);
    end
  endtask

  task automatic test_pc_wrap;
    logic v, r;
    write_word(32'hFFFFFFFC, 32'h41514505, 1'b0);
    write_word(32'h00000000, 32'h00A00093, 1'b0);
    do_branch(32'hFFFFFFFC, 1'b1, v, r);
    exp_push(32'h00004505, 32'hFFFFFFFC, 1'b0);
    exp_push(32'h00004151, 32'hFFFFFFFE, 1'b0);
    exp_push(32'h00A00093, 32'h00000000, 1'b0);
    run_stream(3, 100, 100);
    checks++;
    if (o_data.size() != e_data.size()) begin
      errors++; $display("FAIL wrap_count: got %0d instrs want %0d", o_data.size(), e_data.size());
    end
    for (int i = 0; i < o_data.size() && i < e_data.size(); i++) begin
      checks++;
      if ({o_data[i], o_pc[i], o_err[i], o_comp[i]} !== {e_data[i], e_pc[i], e_err[i], e_comp[i]}) begin
        errors++;
        $display("FAIL wrap #%0d: got d=%h pc=%h e=%b c=%b want d=%h pc=%h e=%b c=%b", i, o_data[i], o_pc[i],
                 o_err[i], o_comp[i], e_data[i], e_pc[i], e_err[i], e_comp[i]);
      end
    end
  endtask

  task automatic test_random;
    logic v, r;
    logic [31:0] start;
    for (int it = 0; it < 12; it++) begin
      for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
      for (int a = 0; a < 512; a++) err_w[a] = ($urandom_range(9) == 0);
      start = 32'($urandom_range(511)) << 1;
      do_branch(start, 1'($urandom), v, r);
      build_expected(start, 20);
      run_stream(20, 70, 70);
      checks++;
      if (o_data.size() != e_data.size()) begin
        errors++; $display("FAIL random_count it%0d: got %0d instrs want %0d", it, o_data.size(), e_data.size());
      end
      for (int i = 0; i < o_data.size() && i < e_data.size(); i++) begin
        checks++;
        if ({o_data[i], o_pc[i], o_err[i], o_comp[i]} !== {e_data[i], e_pc[i], e_err[i], e_comp[i]}) begin
          errors++;
          $display("FAIL random it%0d #%0d: got d=%h pc=%h e=%b c=%b want d=%h pc=%h e=%b c=%b", it, i, o_data[i],
                   o_pc[i], o_err[i], o_comp[i], e_data[i], e_pc[i], e_err[i], e_comp[i]);
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 16'h0;
    for (int a = 0; a < 512; a++) err_w[a] = 1'b0;
    test_reset();
    test_aligned32();
    test_compressed_pair();
    test_straddle();
    test_discard();
    test_errors();
    test_branch_in_resid();
    test_reset_mid();
    test_pc_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
